lagarto_pmu_ctrl: RTL and testbench

- Programmable performance-counter controller for the Lagarto tile.
- Samples the 23-bit per-cycle PMU event vector exported by the core wrapper and routes selected events into a small bank of wide counters.
- Configuration and readout use a single-outstanding request/response register port, driven by the tile's debug/CSR path.
- Raises a maskable overflow interrupt.

---
 rtl/lagarto_pmu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lagarto_pmu_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lagarto_pmu_ctrl.sv
// Performance-counter controller: samples the core PMU event vector and counts
// selected events in a bank of wide counters behind a single-outstanding register port.
module lagarto_pmu_ctrl #(
  parameter int NUM_EVENTS   = 23,
  parameter int NUM_COUNTERS = 4,
  parameter int CNT_WIDTH    = 48
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] pmu_sig_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [7:0]            req_addr_i,
  input  logic [63:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ovf_irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_EVENTS-1:0]                   evt_q;
  logic                                    global_en_q;
  logic                                    freeze_on_ovf_q;
  logic [NUM_COUNTERS-1:0]                 ovf_q;
  logic [NUM_COUNTERS-1:0]                 irq_mask_q;
  logic [NUM_COUNTERS-1:0]                 cnt_en_q;
  logic [NUM_COUNTERS-1:0][4:0]            evsel_q;
  logic [NUM_COUNTERS-1:0][CNT_WIDTH-1:0]  cnt_q;
  logic                                    rsp_valid_q;
  logic [63:0]                             rsp_rdata_q;
  logic                                    rsp_err_q;
  logic                                    ovf_irq_q;

  logic                    accept;
  logic                    wr;
  logic                    hit_ctrl;
  logic                    hit_ovf;
  logic                    hit_mask;
  logic [NUM_COUNTERS-1:0] hit_evsel;
  logic [NUM_COUNTERS-1:0] hit_cnt;
  logic                    addr_ok;
  logic [63:0]             rd_data;
  logic                    frozen;
  logic [31:0]             evt_pad;
  logic [NUM_COUNTERS-1:0] inc;
  logic [NUM_COUNTERS-1:0] wrap;
  logic [NUM_COUNTERS-1:0] ovf_clr;

  // Handshake: a request transfers on req_valid_i & req_ready_o; ready is low while a
  // response is pending, so one request at most is outstanding. The response holds
  // valid/rdata/err stable until rsp_valid_o & rsp_ready_i, then drops next cycle.
  assign req_ready_o = ~rsp_valid_q;
  assign accept      = req_valid_i & req_ready_o;
  assign wr          = accept & req_we_i;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign ovf_irq_o   = ovf_irq_q;

  always_comb begin
    hit_ctrl  = (req_addr_i == 8'h00);
    hit_ovf   = (req_addr_i == 8'h01);
    hit_mask  = (req_addr_i == 8'h02);
    hit_evsel = '0;
    hit_cnt   = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      hit_evsel[i] = (req_addr_i == 8'(16 + i));
      hit_cnt[i]   = (req_addr_i == 8'(32 + i));
    end
    addr_ok = hit_ctrl | hit_ovf | hit_mask | (|hit_evsel) | (|hit_cnt);
  end

  always_comb begin
    rd_data = '0;
    if (hit_ctrl) rd_data = {62'd0, freeze_on_ovf_q, global_en_q};
    if (hit_ovf)  rd_data = 64'(ovf_q);
    if (hit_mask) rd_data = 64'(irq_mask_q);
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (hit_evsel[i]) rd_data = {55'd0, cnt_en_q[i], 3'd0, evsel_q[i]};
      if (hit_cnt[i])   rd_data = 64'(cnt_q[i]);
    end
  end

  // Indices at or above NUM_EVENTS land on the zero padding and never count.
  assign evt_pad = 32'(evt_q);
  assign frozen  = freeze_on_ovf_q & (|ovf_q);

  always_comb begin
    inc  = '0;
    wrap = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      inc[i]  = global_en_q & cnt_en_q[i] & evt_pad[evsel_q[i]] & ~frozen;
      wrap[i] = inc[i] & ~(wr & hit_cnt[i]) & (cnt_q[i] == CNT_MAX);
    end
    ovf_clr = (wr & hit_ovf) ? req_wdata_i[NUM_COUNTERS-1:0] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q           <= '0;
      global_en_q     <= 1'b0;
      freeze_on_ovf_q <= 1'b0;
      ovf_q           <= '0;
      irq_mask_q      <= '0;
      cnt_en_q        <= '0;
      evsel_q         <= '0;
      ovf_irq_q       <= 1'b0;
    end else begin
      evt_q     <= pmu_sig_i;
      ovf_irq_q <= |(ovf_q & irq_mask_q);
      // A wrap on the same edge as a clear keeps the flag set.
      ovf_q     <= (ovf_q & ~ovf_clr) | wrap;
      if (wr && hit_ctrl) begin
        global_en_q     <= req_wdata_i[0];
        freeze_on_ovf_q <= req_wdata_i[1];
      end
      if (wr && hit_mask) irq_mask_q <= req_wdata_i[NUM_COUNTERS-1:0];
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (wr && hit_evsel[i]) begin
          evsel_q[i]  <= req_wdata_i[4:0];
          cnt_en_q[i] <= req_wdata_i[8];
        end
      end
    end
  end

  // A register write to a counter overrides any increment on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (wr && hit_cnt[i]) cnt_q[i] <= req_wdata_i[CNT_WIDTH-1:0];
        else if (inc[i])      cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= req_we_i ? 64'd0 : rd_data;
      rsp_err_q   <= ~addr_ok;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lagarto_pmu_ctrl.sv
// Self-checking bench for lagarto_pmu_ctrl: directed scenarios plus random register
// traffic, all checked against a cycle-level behavioural model of the register file.
module tb_lagarto_pmu_ctrl;
  localparam int NE = 23;
  localparam int NC = 4;
  localparam int CW = 48;
  localparam logic [63:0] CMASK = 64'h0000_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] pmu_sig = NE'(1);
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [7:0]    req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready;
  logic          rsp_valid;
  logic [63:0]   rsp_rdata;
  logic          rsp_err;
  logic          ovf_irq;

  int vectors = 0;
  int miscompares = 0;
  bit rand_evt = 1'b0;
  bit clear_evt_at_issue = 1'b0;

  logic [64:0] exp_q[$];

  // Reference model state: architectural register contents in plain arrays
  logic [63:0]   m_cnt[NC];
  logic [4:0]    m_sel[NC];
  logic [NC-1:0] m_cen;
  logic [NC-1:0] m_ovf;
  logic [NC-1:0] m_mask;
  logic          m_en;
  logic          m_frz;
  logic          m_busy;
  logic          m_irq;
  logic [31:0]   m_evt_prev;

  always #5 clk = ~clk;

  lagarto_pmu_ctrl #(.NUM_EVENTS(NE), .NUM_COUNTERS(NC), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pmu_sig_i  (pmu_sig),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .ovf_irq_o  (ovf_irq)
  );

  always @(negedge clk) begin
    if (rand_evt) pmu_sig = NE'({$urandom, 1'b1});
  end

  function automatic void model_read(input logic [7:0] a, output logic [63:0] rd,
                                     output logic er);
    int idx;
    idx = int'(a);
    rd = '0;
    er = 1'b0;
    if (idx == 0)                        rd = {62'd0, m_frz, m_en};
    else if (idx == 1)                   rd = 64'(m_ovf);
    else if (idx == 2)                   rd = 64'(m_mask);
    else if (idx >= 16 && idx < 16 + NC) rd = (64'(m_cen[idx-16]) << 8) | 64'(m_sel[idx-16]);
    else if (idx >= 32 && idx < 32 + NC) rd = m_cnt[idx-32];
    else                                 er = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    logic          frozen;
    logic          acc;
    logic          er;
    logic          irq_next;
    logic [63:0]   rd;
    logic [NC-1:0] inc_v;
    logic [NC-1:0] set_v;
    logic [NC-1:0] clr_v;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = '0;
        m_sel[i] = '0;
      end
      m_cen = '0; m_ovf = '0; m_mask = '0; m_en = 1'b0; m_frz = 1'b0;
      m_busy = 1'b0; m_irq = 1'b0; m_evt_prev = '0;
      exp_q.delete();
    end else begin
      frozen   = m_frz && (m_ovf != '0);
      irq_next = |(m_ovf & m_mask);
      for (int i = 0; i < NC; i++)
        inc_v[i] = m_en && m_cen[i] && (int'(m_sel[i]) < NE) && m_evt_prev[m_sel[i]] && !frozen;
      acc   = req_valid && !m_busy;
      set_v = '0;
      clr_v = '0;
      if (acc) begin
        model_read(req_addr, rd, er);
        exp_q.push_back({er, req_we ? 64'd0 : rd});
        m_busy = 1'b1;
      end else if (m_busy && rsp_ready) begin
        m_busy = 1'b0;
      end
      for (int i = 0; i < NC; i++) begin
        if (acc && req_we && int'(req_addr) == 32 + i) begin
          m_cnt[i] = req_wdata & CMASK;
        end else if (inc_v[i]) begin
          if (m_cnt[i] == CMASK) begin
            m_cnt[i] = '0;
            set_v[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 64'd1;
          end
        end
      end
      if (acc && req_we) begin
        if (req_addr == 8'h00) begin m_en = req_wdata[0]; m_frz = req_wdata[1]; end
        if (req_addr == 8'h01) clr_v = req_wdata[NC-1:0];
        if (req_addr == 8'h02) m_mask = req_wdata[NC-1:0];
        for (int i = 0; i < NC; i++) begin
          if (int'(req_addr) == 16 + i) begin
            m_sel[i] = req_wdata[4:0];
            m_cen[i] = req_wdata[8];
          end
        end
      end
      m_ovf      = (m_ovf & ~clr_v) | set_v;
      m_irq      = irq_next;
      m_evt_prev = 32'(pmu_sig);
    end
  end

  task automatic bus_xfer(input string name, input logic we, input logic [7:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic err);
    int budget;
    logic [64:0] exp;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    if (clear_evt_at_issue) begin
      pmu_sig = NE'(1);
      clear_evt_at_issue = 1'b0;
    end
    budget = 0;
    while (req_ready !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    @(negedge clk);
    req_valid = 1'b0;
    budget = 0;
    while (rsp_valid !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    rdata = rsp_rdata;
    err   = rsp_err;
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: no response within budget (rsp_valid=%b, need 1)", name, rsp_valid);
    end else if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: response without expected entry (got err=%b rdata=%h)", name, err, rdata);
    end else begin
      exp = exp_q.pop_front();
      if ({err, rdata} !== exp)
        begin
          miscompares++;
          $display("FAIL %s: got err=%b rdata=%h, need err=%b rdata=%h", name, err, rdata,
                   exp[64], exp[63:0]);
        end
    end
  endtask

  task automatic check_val(input string name, input logic [64:0] got, input logic [64:0] need);
    vectors++;
    if (got !== need) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic e;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({req_ready, rsp_valid, ovf_irq, rsp_err} !== 4'b1000 || rsp_rdata !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: got ready=%b valid=%b irq=%b err=%b rdata=%h, need 1 0 0 0 0",
                 req_ready, rsp_valid, ovf_irq, rsp_err, rsp_rdata);
      end
    end
    rst_n = 1'b1;
    bus_xfer("reset_ctrl", 1'b0, 8'h00, 64'd0, d, e);
    check_val("reset_ctrl_const", {e, d}, 65'd0);
    bus_xfer("reset_ovf", 1'b0, 8'h01, 64'd0, d, e);
    check_val("reset_ovf_const", {e, d}, 65'd0);
    bus_xfer("reset_cnt0", 1'b0, 8'h20, 64'd0, d, e);
    check_val("reset_cnt0_const", {e, d}, 65'd0);
  endtask

  task automatic test_cycle_count();
    logic [63:0] d;
    logic e;
    rand_evt = 1'b1;
    bus_xfer("cyc_evsel0", 1'b1, 8'h10, 64'h100, d, e);
    bus_xfer("cyc_ctrl_on", 1'b1, 8'h00, 64'h1, d, e);
    repeat (100) @(negedge clk);
    bus_xfer("cyc_ctrl_off", 1'b1, 8'h00, 64'h0, d, e);
    bus_xfer("cyc_count0", 1'b0, 8'h20, 64'd0, d, e);
    vectors++;
    if (d < 64'd98 || d > 64'd102) begin
      miscompares++;
      $display("FAIL cyc_range: got %0d, need 98..102", d);
    end
  endtask

  task automatic test_selected_event();
    logic [63:0] d;
    logic e;
    @(negedge clk);
    rand_evt = 1'b0;
    pmu_sig  = NE'(1);
    bus_xfer("sel_evsel1", 1'b1, 8'h11, 64'h10B, d, e);
    bus_xfer("sel_ctrl_on", 1'b1, 8'h00, 64'h1, d, e);
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      pmu_sig = NE'(1);
      if (c % 3 == 0)           pmu_sig[11] = 1'b1;
      if (c % 3 == 1 && c < 15) pmu_sig[10] = 1'b1;
    end
    @(negedge clk);
    pmu_sig = NE'(1);
    repeat (3) @(negedge clk);
    bus_xfer("sel_ctrl_off", 1'b1, 8'h00, 64'h0, d, e);
    bus_xfer("sel_count1", 1'b0, 8'h21, 64'd0, d, e);
    check_val("sel_count1_const", {e, d}, {1'b0, 64'd7});
  endtask

  task automatic test_overflow_freeze();
    logic [63:0] d;
    logic [63:0] d2;
    logic e;
    bus_xfer("ovf_cnt2", 1'b1, 8'h22, 64'hFFFF_FFFF_FFFE, d, e);
    bus_xfer("ovf_evsel2", 1'b1, 8'h12, 64'h100, d, e);
    bus_xfer("ovf_mask", 1'b1, 8'h02, 64'h4, d, e);
    bus_xfer("ovf_ctrl", 1'b1, 8'h00, 64'h3, d, e);
    @(negedge clk);
    check_val("ovf_irq_t1", {64'd0, ovf_irq}, 65'd0);
    @(negedge clk);
    check_val("ovf_irq_t2", {64'd0, ovf_irq}, 65'd0);
    @(negedge clk);
    check_val("ovf_irq_t3", {64'd0, ovf_irq}, 65'd1);
    @(negedge clk);
    bus_xfer("ovf_read_cnt2", 1'b0, 8'h22, 64'd0, d, e);
    check_val("ovf_cnt2_frozen", {e, d}, 65'd0);
    bus_xfer("ovf_read_ovf", 1'b0, 8'h01, 64'd0, d, e);
    check_val("ovf_flags", {e, d}, {1'b0, 64'h4});
    bus_xfer("ovf_cnt0_a", 1'b0, 8'h20, 64'd0, d, e);
    repeat (3) @(negedge clk);
    bus_xfer("ovf_cnt0_b", 1'b0, 8'h20, 64'd0, d2, e);
    check_val("ovf_cnt0_held", {1'b0, d2}, {1'b0, d});
    bus_xfer("ovf_w1c", 1'b1, 8'h01, 64'h4, d, e);
    check_val("ovf_irq_before_clr", {64'd0, ovf_irq}, 65'd1);
    @(negedge clk);
    check_val("ovf_irq_after_clr", {64'd0, ovf_irq}, 65'd0);
    repeat (3) @(negedge clk);
    bus_xfer("ovf_resume_cnt2", 1'b0, 8'h22, 64'd0, d, e);
    vectors++;
    if (d == 64'd0) begin
      miscompares++;
      $display("FAIL ovf_resume: got %h, need nonzero", d);
    end
    bus_xfer("ovf_ctrl_off", 1'b1, 8'h00, 64'h0, d, e);
  endtask

  task automatic test_write_conflict();
    logic [63:0] d;
    logic e;
    bus_xfer("wc_evsel0", 1'b1, 8'h10, 64'h105, d, e);
    bus_xfer("wc_ctrl_on", 1'b1, 8'h00, 64'h1, d, e);
    @(negedge clk);
    pmu_sig = NE'(33);
    repeat (3) @(negedge clk);
    clear_evt_at_issue = 1'b1;
    bus_xfer("wc_write", 1'b1, 8'h20, 64'h55, d, e);
    repeat (3) @(negedge clk);
    bus_xfer("wc_ctrl_off", 1'b1, 8'h00, 64'h0, d, e);
    bus_xfer("wc_read", 1'b0, 8'h20, 64'd0, d, e);
    check_val("wc_value_const", {e, d}, {1'b0, 64'h55});
  endtask

  task automatic test_handshake_errors();
    logic [63:0] d;
    logic [63:0] held;
    logic e;
    logic [64:0] exp;
    bus_xfer("err_rd_7f", 1'b0, 8'h7F, 64'd0, d, e);
    check_val("err_rd_7f_const", {e, d}, {1'b1, 64'd0});
    bus_xfer("err_wr_24", 1'b1, 8'h24, 64'h1234, d, e);
    check_val("err_wr_24_const", {e, d}, {1'b1, 64'd0});
    bus_xfer("err_rd_24", 1'b0, 8'h24, 64'd0, d, e);
    check_val("err_rd_24_const", {e, d}, {1'b1, 64'd0});
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h02; req_wdata = '0;
    @(negedge clk);
    req_addr = 8'h00;
    held = rsp_rdata;
    check_val("stall_data_const", {rsp_err, held}, {1'b0, 64'h4});
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
    check_val("stall_data_model", {rsp_err, held}, exp);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got valid=%b ready=%b rdata=%h err=%b, need 1 0 %h 0",
                 k, rsp_valid, req_ready, rsp_rdata, rsp_err, held);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("stall_release", {64'd0, rsp_valid}, 65'd0);
    @(negedge clk);
    check_val("stall_no_second", {64'd0, rsp_valid}, 65'd0);
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic e;
    bus_xfer("rm_ctrl_on", 1'b1, 8'h00, 64'h1, d, e);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    bus_xfer("rm_cnt0", 1'b0, 8'h20, 64'd0, d, e);
    check_val("rm_cnt0_const", {e, d}, 65'd0);
    bus_xfer("rm_ctrl", 1'b0, 8'h00, 64'd0, d, e);
    check_val("rm_ctrl_const", {e, d}, 65'd0);
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [63:0] wd;
    logic e;
    logic [7:0] addr_tab[13];
    logic [7:0] a;
    logic we;
    addr_tab = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13,
                 8'h20, 8'h21, 8'h22, 8'h23, 8'h14, 8'h7F};
    rand_evt = 1'b1;
    bus_xfer("rnd_ctrl_on", 1'b1, 8'h00, 64'h1, d, e);
    for (int n = 0; n < 60; n++) begin
      a  = addr_tab[$urandom_range(0, 12)];
      we = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      if (a == 8'h00) wd[0] = 1'b1;
      if (a >= 8'h10 && a <= 8'h13) wd = {55'd0, 1'b1, 3'd0, 5'($urandom_range(0, 24))};
      if (a >= 8'h20 && a <= 8'h23 && $urandom_range(0, 1) == 0)
        wd = CMASK - 64'($urandom_range(0, 6));
      bus_xfer("rnd_xfer", we, a, wd, d, e);
      check_val("rnd_irq", {64'd0, ovf_irq}, {64'd0, m_irq});
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_cycle_count();
    test_selected_event();
    test_overflow_freeze();
    test_write_conflict();
    test_handshake_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
